// File: rtl/pmod_dac_spi_ctrl_pkg.sv
// Shared types and constants for the Pmod DAC SPI controller.
// Frame layout: {4'h0, cmd, addr, data, 8'h00}, shifted MSB first.
package pmod_dac_pkg;

   localparam int FRAME_W = 32;

   typedef enum logic [2:0] {
      IDLE,
      INIT,
      SHIFT,
      GAP,
      LDAC
   } state_t;

   localparam logic [3:0] CMD_WR_INPUT  = 4'h0;
   localparam logic [3:0] CMD_WR_UPDATE = 4'h3;
   localparam logic [3:0] CMD_REF_SETUP = 4'h8;

   localparam logic [FRAME_W-1:0] INT_REF_FRAME = 32'h0800_0001;

   function automatic logic [FRAME_W-1:0] build_frame(input logic [3:0]  cmd,
                                                      input logic [3:0]  addr,
                                                      input logic [11:0] data);
      return {4'h0, cmd, addr, data, 8'h00};
   endfunction

endpackage

// File: rtl/pmod_dac_spi_ctrl_if.sv
// Request handshake bundle between the pattern source (master) and the SPI controller (slave).
// A request transfers on the clock edge where req_valid and req_ready are both high.
interface pmod_dac_spi_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic [3:0]  req_cmd;
   logic [3:0]  req_addr;
   logic [11:0] req_data;

   modport master (output req_valid, req_cmd, req_addr, req_data, input req_ready);
   modport slave  (input req_valid, req_cmd, req_addr, req_data, output req_ready);
endinterface

// File: rtl/pmod_dac_sclk_gen.sv
// SPI clock generator: while run is high, sclk toggles every CLK_DIV/2 cycles starting from a full high phase;
// rise_stb/fall_stb flag the edge on which sclk is about to rise/fall. Idles high when run is low.
module pmod_dac_sclk_gen #(
   parameter int CLK_DIV = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   output logic sclk,
   output logic rise_stb,
   output logic fall_stb
);
   localparam int H  = CLK_DIV / 2;
   localparam int PW = (H > 1) ? $clog2(H) : 1;
   localparam logic [PW-1:0] PH_LAST = PW'(H - 1);

   logic [PW-1:0] phase_q, phase_d;
   logic          sclk_q, sclk_d;
   logic          wrap;

   always_comb begin
      wrap    = run && (phase_q == PH_LAST);
      phase_d = phase_q;
      sclk_d  = sclk_q;
      if (!run) begin
         phase_d = '0;
         sclk_d  = 1'b1;
      end else if (wrap) begin
         phase_d = '0;
         sclk_d  = ~sclk_q;
      end else begin
         phase_d = phase_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q <= '0;
         sclk_q  <= 1'b1;
      end else begin
         phase_q <= phase_d;
         sclk_q  <= sclk_d;
      end
   end

   assign sclk     = sclk_q;
   assign rise_stb = wrap & ~sclk_q;
   assign fall_stb = wrap & sclk_q;

endmodule

// File: rtl/pmod_dac_spi_ctrl.sv
// Serializes {cmd,addr,data} requests into 32-bit Pmod DAC SPI frames; PMOD_DAC_INT_REF_EN sends a ref-setup frame after reset.
// Latency accept->done = 1 + 32*CLK_DIV + CS_GAP (+ LDAC_PULSE for write-input); req_ready is high only in IDLE.
module pmod_dac_spi_ctrl
   import pmod_dac_pkg::*;
#(
   parameter int CLK_DIV    = 16,
   parameter int CS_GAP     = 8,
   parameter int LDAC_PULSE = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   pmod_dac_spi_ctrl_if.slave req,
   output logic               busy,
   output logic               done,
   output logic               dac_cs_n,
   output logic               dac_ldac_n,
   output logic               dac_din,
   output logic               dac_sclk
);
   localparam int BW      = $clog2(FRAME_W);
   localparam int CNT_MAX = (CS_GAP > LDAC_PULSE) ? CS_GAP : LDAC_PULSE;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] GAP_LAST  = CW'(CS_GAP - 1);
   localparam logic [CW-1:0] LDAC_LAST = CW'(LDAC_PULSE - 1);
   localparam logic [BW-1:0] BIT_MSB   = BW'(FRAME_W - 1);
`ifdef PMOD_DAC_INT_REF_EN
   localparam state_t RST_STATE = INIT;
`else
   localparam state_t RST_STATE = IDLE;
`endif

   state_t               state_q, state_d;
   logic [FRAME_W-2:0]   sr_q, sr_d;
   logic [BW-1:0]        bit_q, bit_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 ready_q, ready_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 cs_n_q, cs_n_d;
   logic                 ldac_n_q, ldac_n_d;
   logic                 din_q, din_d;
   logic                 ldac_req_q, ldac_req_d;
   logic                 silent_q, silent_d;

   logic                 load_en;
   logic [FRAME_W-1:0]   load_frame;
   logic                 run, sclk, rise_stb, fall_stb;

   assign run = (state_q == SHIFT);

   pmod_dac_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
      .clk      (clk),
      .rst_n    (rst_n),
      .run      (run),
      .sclk     (sclk),
      .rise_stb (rise_stb),
      .fall_stb (fall_stb)
   );

   always_comb begin
      state_d    = state_q;
      sr_d       = sr_q;
      bit_d      = bit_q;
      cnt_d      = cnt_q;
      cs_n_d     = cs_n_q;
      ldac_n_d   = ldac_n_q;
      din_d      = din_q;
      ldac_req_d = ldac_req_q;
      silent_d   = silent_q;
      done_d     = 1'b0;
      load_en    = 1'b0;
      load_frame = '0;

      case (state_q)
         IDLE: begin
            if (ready_q && req.req_valid) begin
               load_en    = 1'b1;
               load_frame = build_frame(req.req_cmd, req.req_addr, req.req_data);
               ldac_req_d = (req.req_cmd == CMD_WR_INPUT);
               silent_d   = 1'b0;
            end
         end
         // Power-up reference frame: no LDAC and no done pulse.
         INIT: begin
            load_en    = 1'b1;
            load_frame = INT_REF_FRAME;
            ldac_req_d = 1'b0;
            silent_d   = 1'b1;
         end
         SHIFT: begin
            if (rise_stb) begin
               if (bit_q == '0) begin
                  state_d = GAP;
                  cs_n_d  = 1'b1;
                  din_d   = 1'b0;
                  cnt_d   = '0;
               end else begin
                  din_d = sr_q[FRAME_W-2];
                  sr_d  = {sr_q[FRAME_W-3:0], 1'b0};
                  bit_d = bit_q - 1'b1;
               end
            end
         end
         GAP: begin
            if (cnt_q == GAP_LAST) begin
               cnt_d = '0;
               if (ldac_req_q) begin
                  state_d  = LDAC;
                  ldac_n_d = 1'b0;
               end else begin
                  state_d = IDLE;
                  done_d  = ~silent_q;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         LDAC: begin
            if (cnt_q == LDAC_LAST) begin
               state_d  = IDLE;
               ldac_n_d = 1'b1;
               done_d   = ~silent_q;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // The MSB goes straight to din; the shift register holds only the bits still to send.
      if (load_en) begin
         state_d = SHIFT;
         sr_d    = load_frame[FRAME_W-2:0];
         din_d   = load_frame[FRAME_W-1];
         bit_d   = BIT_MSB;
         cs_n_d  = 1'b0;
      end

      ready_d = (state_d == IDLE);
      busy_d  = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= RST_STATE;
         sr_q       <= '0;
         bit_q      <= '0;
         cnt_q      <= '0;
         ready_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         cs_n_q     <= 1'b1;
         ldac_n_q   <= 1'b1;
         din_q      <= 1'b0;
         ldac_req_q <= 1'b0;
         silent_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         sr_q       <= sr_d;
         bit_q      <= bit_d;
         cnt_q      <= cnt_d;
         ready_q    <= ready_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         cs_n_q     <= cs_n_d;
         ldac_n_q   <= ldac_n_d;
         din_q      <= din_d;
         ldac_req_q <= ldac_req_d;
         silent_q   <= silent_d;
      end
   end

   a_fall_in_frame: assert property (@(posedge clk) disable iff (!rst_n) fall_stb |-> !cs_n_q);

   assign req.req_ready = ready_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign dac_cs_n      = cs_n_q;
   assign dac_ldac_n    = ldac_n_q;
   assign dac_din       = din_q;
   assign dac_sclk      = sclk;

endmodule

// File: tb/tb_pmod_dac_spi_ctrl.sv
// Scoreboard bench for pmod_dac_spi_ctrl: random and directed requests, SPI frame decode, timing and mid-frame reset.
module tb_pmod_dac_spi_ctrl;
   import pmod_dac_pkg::*;

   localparam int CLK_DIV    = 16;
   localparam int CS_GAP     = 8;
   localparam int LDAC_PULSE = 8;
   localparam int H          = CLK_DIV / 2;
   localparam int SHIFT_CYC  = 32 * CLK_DIV;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic busy, done, dac_cs_n, dac_ldac_n, dac_din, dac_sclk;

   pmod_dac_spi_ctrl_if req_if();

   pmod_dac_spi_ctrl #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP), .LDAC_PULSE(LDAC_PULSE)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (req_if.slave),
      .busy       (busy),
      .done       (done),
      .dac_cs_n   (dac_cs_n),
      .dac_ldac_n (dac_ldac_n),
      .dac_din    (dac_din),
      .dac_sclk   (dac_sclk)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] frame;
      bit          b2b;
      logic [3:0]  prev_cmd;
   } fexp_t;

   typedef struct {
      int         acc;
      int         lat;
      logic [3:0] cmd;
   } dexp_t;

   fexp_t fq[$];
   dexp_t dq[$];

   int         checks = 0;
   int         errors = 0;
   bit         mon_en = 1'b0;
   bit         held = 1'b0;
   int         last_acc = 0;
   int         last_lat = 0;
   logic [3:0] last_cmd = 4'h0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] model_frame(input logic [3:0] c, input logic [3:0] a, input logic [11:0] d);
      return (32'(c) << 24) | (32'(a) << 20) | (32'(d) << 8);
   endfunction

   function automatic int model_lat(input logic [3:0] c);
      return 1 + SHIFT_CYC + CS_GAP + ((c == CMD_WR_INPUT) ? LDAC_PULSE : 0);
   endfunction

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Called at a negedge; presents junk while req_ready is low, the real request once it is high.
   task automatic send(input logic [3:0] c, input logic [3:0] a, input logic [11:0] d, input bit hold);
      bit ok;
      ok = 1'b0;
      req_if.req_valid = 1'b1;
      for (int t = 0; t < 4000 && !ok; t++) begin
         if (req_if.req_ready) begin
            req_if.req_cmd  = c;
            req_if.req_addr = a;
            req_if.req_data = d;
            if (held) chk("b2b_accept_cycle", cyc, last_acc + last_lat);
            fq.push_back('{model_frame(c, a, d), held, last_cmd});
            dq.push_back('{cyc, model_lat(c), c});
            last_acc = cyc;
            last_lat = model_lat(c);
            last_cmd = c;
            held     = hold;
            ok       = 1'b1;
         end else begin
            req_if.req_cmd  = 4'($urandom);
            req_if.req_addr = 4'($urandom);
            req_if.req_data = 12'($urandom);
         end
         @(negedge clk);
      end
      if (!ok) chk("accept_timeout", 0, 1);
      if (!hold) req_if.req_valid = 1'b0;
   endtask

   task automatic drain();
      for (int t = 0; t < 3000 && (fq.size() != 0 || dq.size() != 0); t++) @(negedge clk);
      chk("drain_outstanding", fq.size() + dq.size(), 0);
   endtask

   task automatic release_reset();
      int rel;
      int exp_rdy;
`ifdef PMOD_DAC_INT_REF_EN
      fq.push_back('{INT_REF_FRAME, 1'b0, 4'h0});
      exp_rdy = 1 + SHIFT_CYC + CS_GAP;
`else
      exp_rdy = 1;
`endif
      held   = 1'b0;
      rel    = cyc;
      rst_n  = 1'b1;
      mon_en = 1'b1;
      for (int t = 0; t < 2000 && !req_if.req_ready; t++) @(negedge clk);
      chk("ready_rise_cycle", cyc - rel, exp_rdy);
      chk("idle_cs_n", dac_cs_n, 1);
      chk("idle_ldac_n", dac_ldac_n, 1);
      chk("idle_sclk", dac_sclk, 1);
      chk("idle_din", dac_din, 0);
   endtask

   // Monitor state
   logic        prev_cs = 1'b1;
   logic        prev_sclk = 1'b1;
   int          run_len = 0;
   int          nbits = 0;
   int          cs_high = 1000;
   int          ldac_cnt = 0;
   logic [31:0] bits = '0;

   initial begin : monitor
      fexp_t fe;
      dexp_t de;
      forever begin
         @(negedge clk);
         if (!rst_n || !mon_en) begin
            run_len  = 0;
            nbits    = 0;
            cs_high  = 1000;
            ldac_cnt = 0;
         end else begin
            if (!prev_cs) begin
               if (dac_sclk != prev_sclk) begin
                  chk("sclk_half_period", run_len, H);
                  run_len = 1;
                  if (!dac_sclk) begin
                     bits = {bits[30:0], dac_din};
                     nbits++;
                  end
               end else begin
                  run_len++;
               end
               if (dac_cs_n) begin
                  chk("frame_expected", fq.size() != 0, 1);
                  if (fq.size() != 0) begin
                     fe = fq.pop_front();
                     chk("frame_bit_count", nbits, 32);
                     chk("frame_data", bits, fe.frame);
                  end
                  chk("din_low_after_frame", dac_din, 0);
                  chk("sclk_high_after_frame", dac_sclk, 1);
                  cs_high = 1;
               end
            end else if (!dac_cs_n) begin
               chk("frame_expected_at_cs", fq.size() != 0, 1);
               if (fq.size() != 0) begin
                  fe = fq[0];
                  if (fe.b2b)
                     chk("cs_gap_b2b", cs_high,
                         CS_GAP + 1 + ((fe.prev_cmd == CMD_WR_INPUT) ? LDAC_PULSE : 0));
                  else
                     chk("cs_gap_min", cs_high >= CS_GAP + 1, 1);
               end
               chk("sclk_high_at_cs_fall", dac_sclk, 1);
               chk("busy_in_frame", busy, 1);
               run_len = 1;
               nbits   = 0;
               bits    = '0;
            end else begin
               cs_high++;
            end

            if (!dac_ldac_n) begin
               ldac_cnt++;
               chk("ldac_only_with_cs_high", dac_cs_n, 1);
            end

            if (done) begin
               chk("done_expected", dq.size() != 0, 1);
               if (dq.size() != 0) begin
                  de = dq.pop_front();
                  chk("done_latency", cyc - de.acc, de.lat);
                  chk("ldac_low_cycles", ldac_cnt, (de.cmd == CMD_WR_INPUT) ? LDAC_PULSE : 0);
               end
               chk("ready_at_done", req_if.req_ready, 1);
               chk("busy_at_done", busy, 0);
               ldac_cnt = 0;
            end
         end
         prev_cs   = dac_cs_n;
         prev_sclk = dac_sclk;
      end
   end

   initial begin : main
      int acc;
      logic [3:0] c;
      bit h;
      req_if.req_valid = 1'b0;
      req_if.req_cmd   = 4'h0;
      req_if.req_addr  = 4'h0;
      req_if.req_data  = 12'h000;

      repeat (3) @(negedge clk);
      chk("rst_ready", req_if.req_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_cs_n", dac_cs_n, 1);
      chk("rst_ldac_n", dac_ldac_n, 1);
      chk("rst_sclk", dac_sclk, 1);
      chk("rst_din", dac_din, 0);
      release_reset();

      // Directed: write+update, write-input with LDAC, then three held back-to-back.
      send(4'h3, 4'h2, 12'hABC, 1'b0);
      idle(5);
      send(4'h0, 4'hF, 12'hFFF, 1'b0);
      idle(3);
      send(4'h3, 4'h1, 12'h111, 1'b1);
      send(4'h3, 4'h4, 12'h5A5, 1'b1);
      send(4'h3, 4'h7, 12'h800, 1'b0);

      for (int i = 0; i < 10; i++) begin
         case ($urandom_range(0, 3))
            0:       c = CMD_WR_INPUT;
            1:       c = CMD_WR_UPDATE;
            2:       c = CMD_REF_SETUP;
            default: c = 4'($urandom);
         endcase
         h = ($urandom_range(0, 1) == 1) && (i != 9);
         send(c, 4'($urandom), 12'($urandom), h);
         if (!h) idle($urandom_range(0, 20));
      end
      drain();

      // Reset in the low phase of bit 10 of an unscored frame.
      mon_en = 1'b0;
      idle(2);
      chk("ready_before_abort", req_if.req_ready, 1);
      req_if.req_valid = 1'b1;
      req_if.req_cmd   = 4'h3;
      req_if.req_addr  = 4'h5;
      req_if.req_data  = 12'h123;
      acc = cyc;
      @(negedge clk);
      req_if.req_valid = 1'b0;
      idle(10 * CLK_DIV + 12 - 1);
      chk("abort_cycle", cyc - acc, 10 * CLK_DIV + 12);
      chk("abort_cs_low", dac_cs_n, 0);
      chk("abort_sclk_low", dac_sclk, 0);
      rst_n = 1'b0;
      #1;
      chk("abort_cs_n", dac_cs_n, 1);
      chk("abort_sclk", dac_sclk, 1);
      chk("abort_din", dac_din, 0);
      chk("abort_busy", busy, 0);
      chk("abort_ready", req_if.req_ready, 0);
      chk("abort_ldac_n", dac_ldac_n, 1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("abort_no_done", done, 0);
      end
      release_reset();
      chk("post_abort_no_done", done, 0);

      send(4'h3, 4'($urandom), 12'($urandom), 1'b0);
      idle(4);
      send(4'h0, 4'($urandom), 12'($urandom), 1'b0);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
